adc_serial_responder: RTL and testbench

ADC-side responder for the board's framed serial ADC link. It emulates the 4-channel converter: it accepts 16-bit control words framed by TFS, performs a timed "conversion" of the selected channel's sample input, and shifts the 16-bit result out framed by RFS. It runs on CLOCK_50 and treats SCLK, TFS and RFS as asynchronous inputs. Its purpose is closed-loop bring-up and simulation of the ADC data-control path without the physical converter.

---
 rtl/adc_serial_pkg.sv | 39 +++
 rtl/sync_edge.sv | 39 +++
 rtl/adc_serial_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_adc_serial_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_serial_pkg.sv
// Shared constants, state encoding and result packing for the ADC serial responder.
package adc_serial_pkg;

    localparam int unsigned WORD_W      = 16;
    localparam int unsigned SMP_W       = 11;
    localparam int unsigned CONV_CYCLES = 100;
    localparam int unsigned CONV_CNT_W  = $clog2(CONV_CYCLES);

    // Result word field positions
    localparam int unsigned CH_MSB  = 15;
    localparam int unsigned CH_LSB  = 14;
    localparam int unsigned SMP_MSB = 10;

    // Control word fields
    localparam int unsigned WR_EN_BIT  = 15;
    localparam int unsigned CH_SEL_MSB = 1;
    localparam int unsigned CH_SEL_LSB = 0;

    // Receive bit counter saturates one past a full word so long frames stay distinguishable
    localparam int unsigned BIT_CNT_W   = 5;
    localparam int unsigned BIT_CNT_MAX = WORD_W + 1;
    localparam int unsigned ERR_CNT_W   = 8;

    typedef enum logic [0:0] {
        StIdle,
        StConv
    } conv_state_e;

    // Pack channel and sample into the result word; unused middle bits are zero
    function automatic logic [WORD_W-1:0] build_result(input logic [1:0]       ch,
                                                       input logic [SMP_W-1:0] smp);
        logic [WORD_W-1:0] word;
        word                  = '0;
        word[CH_MSB:CH_LSB]   = ch;
        word[SMP_MSB:0]       = smp;
        return word;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin with single-cycle rise/fall pulses.
module sync_edge #(
    parameter bit ResetVal = 1'b0
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Next-state for the synchronizer chain and the edge-history flop
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Reset to the pin's idle level so release does not fake an edge
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
            prev_q <= ResetVal;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/adc_serial_responder.sv
// Emulated 4-channel serial ADC: framed control words in, timed conversion, framed result out.
module adc_serial_responder
    import adc_serial_pkg::*;
(
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    input  logic                 sclk_in,
    input  logic                 tfs_n,
    input  logic                 rfs_n,
    input  logic                 din,
    output logic                 dout,
    output logic                 dout_oe,
    input  logic [SMP_W-1:0]     ch0_smp,
    input  logic [SMP_W-1:0]     ch1_smp,
    input  logic [SMP_W-1:0]     ch2_smp,
    input  logic [SMP_W-1:0]     ch3_smp,
    output logic                 conv_busy,
    output logic [1:0]           last_ch,
    output logic [ERR_CNT_W-1:0] frame_err_cnt
);

    logic sclk_rise, sclk_fall;
    logic tfs_rise, tfs_fall;
    logic rfs_rise, rfs_fall;

    sync_edge #(.ResetVal(1'b0)) u_sync_sclk (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .d_i      (sclk_in),
        .rise_o   (sclk_rise),
        .fall_o   (sclk_fall)
    );

    sync_edge #(.ResetVal(1'b1)) u_sync_tfs (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .d_i      (tfs_n),
        .rise_o   (tfs_rise),
        .fall_o   (tfs_fall)
    );

    sync_edge #(.ResetVal(1'b1)) u_sync_rfs (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .d_i      (rfs_n),
        .rise_o   (rfs_rise),
        .fall_o   (rfs_fall)
    );

    // din needs the same two-flop delay as sclk so data lines up with the SCLK rise pulse
    logic din_meta_q, din_meta_d;
    logic din_s_q, din_s_d;

    // RX engine state
    logic                 rx_active_q, rx_active_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]    rx_shift_q, rx_shift_d;
    logic                 accept_q, accept_d;
    logic [1:0]           accept_ch_q, accept_ch_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Conversion state
    conv_state_e           state_q, state_d;
    logic [CONV_CNT_W-1:0] conv_cnt_q, conv_cnt_d;
    logic [1:0]            conv_ch_q, conv_ch_d;
    logic [WORD_W-1:0]     result_q, result_d;
    logic [1:0]            last_ch_q, last_ch_d;
    logic [SMP_W-1:0]      smp_sel;

    // TX engine state
    logic              tx_active_q, tx_active_d;
    logic [WORD_W-1:0] tx_shift_q, tx_shift_d;
    logic              dout_q, dout_d;
    logic              dout_oe_q, dout_oe_d;

    // din synchronizer
    always_comb begin
        din_meta_d = din;
        din_s_d    = din_meta_q;
    end

    // RX: frame tracking, bit capture and end-of-frame classification
    always_comb begin
        rx_active_d = rx_active_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        accept_d    = 1'b0;
        accept_ch_d = accept_ch_q;
        err_cnt_d   = err_cnt_q;
        if (tfs_fall) begin
            rx_active_d = 1'b1;
            bit_cnt_d   = '0;
            rx_shift_d  = '0;
        end else if (tfs_rise && rx_active_q) begin
            rx_active_d = 1'b0;
            if (bit_cnt_q == BIT_CNT_W'(WORD_W)) begin
                // Full word with the write-enable clear is a legal no-op
                if (rx_shift_q[WR_EN_BIT]) begin
                    accept_d    = 1'b1;
                    accept_ch_d = rx_shift_q[CH_SEL_MSB:CH_SEL_LSB];
                end
            end else if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end else if (rx_active_q && sclk_rise) begin
            rx_shift_d = {rx_shift_q[WORD_W-2:0], din_s_q};
            if (bit_cnt_q != BIT_CNT_W'(BIT_CNT_MAX)) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    // Sample source for the channel being converted
    always_comb begin
        case (conv_ch_q)
            2'd0:    smp_sel = ch0_smp;
            2'd1:    smp_sel = ch1_smp;
            2'd2:    smp_sel = ch2_smp;
            default: smp_sel = ch3_smp;
        endcase
    end

    // Conversion FSM: a new accept always restarts, abandoning any conversion in flight
    always_comb begin
        state_d    = state_q;
        conv_cnt_d = conv_cnt_q;
        conv_ch_d  = conv_ch_q;
        result_d   = result_q;
        last_ch_d  = last_ch_q;
        if (accept_q) begin
            state_d    = StConv;
            conv_cnt_d = CONV_CNT_W'(CONV_CYCLES - 1);
            conv_ch_d  = accept_ch_q;
        end else begin
            case (state_q)
                StIdle: ;
                StConv: begin
                    if (conv_cnt_q == '0) begin
                        result_d  = build_result(conv_ch_q, smp_sel);
                        last_ch_d = conv_ch_q;
                        state_d   = StIdle;
                    end else begin
                        conv_cnt_d = conv_cnt_q - 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // TX: load from result_d so a completion in the same cycle as the RFS fall is seen
    always_comb begin
        tx_active_d = tx_active_q;
        tx_shift_d  = tx_shift_q;
        if (rfs_fall) begin
            tx_active_d = 1'b1;
            tx_shift_d  = result_d;
        end else if (rfs_rise) begin
            tx_active_d = 1'b0;
        end else if (tx_active_q && sclk_fall) begin
            tx_shift_d = {tx_shift_q[WORD_W-2:0], 1'b0};
        end
        dout_oe_d = tx_active_q;
        dout_d    = tx_active_q & tx_shift_q[WORD_W-1];
    end

    // Input, RX and conversion registers
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            din_meta_q  <= 1'b0;
            din_s_q     <= 1'b0;
            rx_active_q <= 1'b0;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            accept_q    <= 1'b0;
            accept_ch_q <= '0;
            err_cnt_q   <= '0;
            state_q     <= StIdle;
            conv_cnt_q  <= '0;
            conv_ch_q   <= '0;
            result_q    <= '0;
            last_ch_q   <= '0;
        end else begin
            din_meta_q  <= din_meta_d;
            din_s_q     <= din_s_d;
            rx_active_q <= rx_active_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            accept_q    <= accept_d;
            accept_ch_q <= accept_ch_d;
            err_cnt_q   <= err_cnt_d;
            state_q     <= state_d;
            conv_cnt_q  <= conv_cnt_d;
            conv_ch_q   <= conv_ch_d;
            result_q    <= result_d;
            last_ch_q   <= last_ch_d;
        end
    end

    // TX registers; dout is registered once more after the shifter
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            tx_active_q <= 1'b0;
            tx_shift_q  <= '0;
            dout_q      <= 1'b0;
            dout_oe_q   <= 1'b0;
        end else begin
            tx_active_q <= tx_active_d;
            tx_shift_q  <= tx_shift_d;
            dout_q      <= dout_d;
            dout_oe_q   <= dout_oe_d;
        end
    end

    assign dout          = dout_q;
    assign dout_oe       = dout_oe_q;
    assign conv_busy     = (state_q == StConv);
    assign last_ch       = last_ch_q;
    assign frame_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench for adc_serial_responder: vector table plus multi-cycle corner sequences.
module tb_adc_serial_responder;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n  = 1'b0;
    logic        sclk_in  = 1'b0;
    logic        tfs_n    = 1'b1;
    logic        rfs_n    = 1'b1;
    logic        din      = 1'b0;
    logic [10:0] ch0_smp, ch1_smp, ch2_smp, ch3_smp;
    logic        dout, dout_oe, conv_busy;
    logic [1:0]  last_ch;
    logic [7:0]  frame_err_cnt;

    adc_serial_responder dut (
        .CLOCK_50      (CLOCK_50),
        .reset_n       (reset_n),
        .sclk_in       (sclk_in),
        .tfs_n         (tfs_n),
        .rfs_n         (rfs_n),
        .din           (din),
        .dout          (dout),
        .dout_oe       (dout_oe),
        .ch0_smp       (ch0_smp),
        .ch1_smp       (ch1_smp),
        .ch2_smp       (ch2_smp),
        .ch3_smp       (ch3_smp),
        .conv_busy     (conv_busy),
        .last_ch       (last_ch),
        .frame_err_cnt (frame_err_cnt)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Advance n clock edges, then step off the edge before driving pins
    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #2;
    endtask

    // TFS frame of nbits (bits beyond 16 are zero), SCLK half-period of h cycles
    task automatic send_frame(input logic [15:0] w, input int nbits, input int h);
        tfs_n = 1'b0;
        cyc(h);
        for (int i = 0; i < nbits; i++) begin
            din = (i < 16) ? w[15-i] : 1'b0;
            cyc(h);
            sclk_in = 1'b1;
            cyc(h);
            sclk_in = 1'b0;
        end
        cyc(h);
        tfs_n = 1'b1;
        din   = 1'b0;
    endtask

    // RFS frame: sample nbits MSB-first into bits; oe0 is dout_oe at the first sample
    task automatic read_frame(input int nbits, input bit close, output logic [31:0] bits,
                              output logic oe0);
        logic [31:0] acc;
        acc   = '0;
        rfs_n = 1'b0;
        cyc(6);
        @(negedge CLOCK_50);
        oe0 = dout_oe;
        acc = {acc[30:0], dout};
        for (int i = 1; i < nbits; i++) begin
            cyc(1);
            sclk_in = 1'b1;
            cyc(5);
            sclk_in = 1'b0;
            cyc(6);
            @(negedge CLOCK_50);
            acc = {acc[30:0], dout};
        end
        if (close) begin
            cyc(1);
            rfs_n = 1'b1;
        end
        bits = acc;
    endtask

    // Called right after a TFS rise: busy at the 3rd edge, then length of the busy run from the 4th
    task automatic watch_busy(output logic busy_p3, output int n);
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        busy_p3 = conv_busy;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        n = 0;
        while (conv_busy === 1'b1 && n < 300) begin
            n++;
            @(negedge CLOCK_50);
        end
    endtask

    typedef struct {
        logic [15:0] word;
        int          nbits;
        bit          accept;
        bit          err_inc;
        logic [1:0]  exp_last;
        logic [15:0] exp_result;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] bits;
    logic        oe0, busy_p3;
    int          nbusy;
    int          exp_err;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        ch0_smp = 11'h123;
        ch1_smp = 11'h7FF;
        ch2_smp = 11'h3A5;
        ch3_smp = 11'h400;
        exp_err = 0;

        // Reset held with SCLK toggling
        for (int i = 0; i < 5; i++) begin
            sclk_in = ~sclk_in;
            cyc(1);
        end
        @(negedge CLOCK_50);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dout_oe", 32'(dout_oe), 32'd0);
        check("rst_busy", 32'(conv_busy), 32'd0);
        check("rst_err", 32'(frame_err_cnt), 32'd0);
        check("rst_last_ch", 32'(last_ch), 32'd0);
        sclk_in = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        cyc(5);

        vecs[0] = '{16'h8002, 16, 1'b1, 1'b0, 2'd2, 16'h83A5};
        vecs[1] = '{16'h0001, 16, 1'b0, 1'b0, 2'd2, 16'h83A5};
        vecs[2] = '{16'h8002, 12, 1'b0, 1'b1, 2'd2, 16'h83A5};
        vecs[3] = '{16'h8003, 16, 1'b1, 1'b0, 2'd3, 16'hC400};
        vecs[4] = '{16'h8000, 17, 1'b0, 1'b1, 2'd3, 16'hC400};
        vecs[5] = '{16'h8000, 16, 1'b1, 1'b0, 2'd0, 16'h0123};

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].word, vecs[v].nbits, 5);
            if (vecs[v].err_inc) exp_err++;
            watch_busy(busy_p3, nbusy);
            check($sformatf("v%0d_busy_early", v), 32'(busy_p3), 32'd0);
            check($sformatf("v%0d_busy_cycles", v), 32'(nbusy),
                  vecs[v].accept ? 32'd100 : 32'd0);
            check($sformatf("v%0d_err_cnt", v), 32'(frame_err_cnt), 32'(exp_err));
            check($sformatf("v%0d_last_ch", v), 32'(last_ch), 32'(vecs[v].exp_last));
            read_frame(16, 1'b1, bits, oe0);
            check($sformatf("v%0d_oe", v), 32'(oe0), 32'd1);
            check($sformatf("v%0d_result", v), bits[15:0], 32'(vecs[v].exp_result));
            cyc(6);
            @(negedge CLOCK_50);
            check($sformatf("v%0d_oe_off", v), 32'(dout_oe), 32'd0);
        end

        // Restart: ch1 accepted mid-conversion of ch3; SCLK compressed so it lands in the window
        send_frame(16'h8003, 16, 5);
        cyc(4);
        @(negedge CLOCK_50);
        check("restart_first_busy", 32'(conv_busy), 32'd1);
        send_frame(16'h8001, 16, 2);
        watch_busy(busy_p3, nbusy);
        check("restart_still_busy", 32'(busy_p3), 32'd1);
        check("restart_busy_cycles", 32'(nbusy), 32'd100);
        check("restart_last_ch", 32'(last_ch), 32'd1);
        read_frame(16, 1'b1, bits, oe0);
        check("restart_result", bits[15:0], 32'h47FF);
        cyc(6);

        // ch0 result, then RFS frame during a ch2 conversion streams the older result
        send_frame(16'h8000, 16, 5);
        watch_busy(busy_p3, nbusy);
        check("ch0_busy_cycles", 32'(nbusy), 32'd100);
        send_frame(16'h8002, 16, 5);
        cyc(4);
        read_frame(20, 1'b1, bits, oe0);
        check("rfs_during_conv", bits[19:4], 32'h0123);
        check("rfs_tail_zero", bits[3:0], 32'h0);
        cyc(6);
        @(negedge CLOCK_50);
        check("rfs_close_oe", 32'(dout_oe), 32'd0);
        check("rfs_close_dout", 32'(dout), 32'd0);
        check("ch2_last_ch", 32'(last_ch), 32'd2);

        // Reset at bit 8 of an RFS frame while a conversion is running
        send_frame(16'h8003, 16, 5);
        cyc(4);
        read_frame(8, 1'b0, bits, oe0);
        check("rst_frame_byte", bits[7:0], 32'h83);
        check("rst_frame_busy", 32'(conv_busy), 32'd1);
        cyc(1);
        reset_n = 1'b0;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("midrst_oe", 32'(dout_oe), 32'd0);
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_busy", 32'(conv_busy), 32'd0);
        check("midrst_last_ch", 32'(last_ch), 32'd0);
        check("midrst_err", 32'(frame_err_cnt), 32'd0);
        rfs_n = 1'b1;
        cyc(2);
        reset_n = 1'b1;
        cyc(5);
        read_frame(16, 1'b1, bits, oe0);
        check("midrst_result", bits[15:0], 32'h0);
        cyc(6);

        // Short frames: counter climbs then saturates
        for (int i = 0; i < 300; i++) begin
            send_frame(16'h8000, 1, 5);
            cyc(6);
            if (i == 99) begin
                @(negedge CLOCK_50);
                check("err_after_100", 32'(frame_err_cnt), 32'd100);
            end
        end
        @(negedge CLOCK_50);
        check("err_saturated", 32'(frame_err_cnt), 32'd255);
        check("err_no_conv", 32'(conv_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
